// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared frame-buffer constants, RGB444 colours and arbiter state type
package fb_pkg;

  localparam int AW       = 19;      // frame-buffer address width
  localparam int DW       = 12;      // RGB444 pixel width
  localparam int FB_WORDS = 307200;  // 640x480 valid words

  localparam logic [DW-1:0] RGB_BLACK = 12'h000;
  localparam logic [DW-1:0] RGB_WHITE = 12'hFFF;
  localparam logic [DW-1:0] RGB_RED   = 12'hF00;
  localparam logic [DW-1:0] RGB_GREEN = 12'h0F0;
  localparam logic [DW-1:0] RGB_BLUE  = 12'h00F;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last-grant memory
//   clk, rst      : clock, synchronous active-high reset
//   en            : grants allowed this cycle
//   req_a, req_b  : request lines
//   gnt_a, gnt_b  : combinational one-hot grant (a grant is a transfer)
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  // 1 when B was granted most recently; reset to B so A wins first contention
  logic last_b;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && (!req_b || last_b)) begin
        gnt_a = 1'b1;
      end else if (req_b) begin
        gnt_b = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (gnt_a) begin
      last_b <= 1'b0;
    end else if (gnt_b) begin
      last_b <= 1'b1;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - two-requester frame-buffer write arbiter with optional clear engine
//   Build option: define FB_WRITE_ARB_CLEAR_EN to compile in the clear engine.
//   clk, rst                              : clock, synchronous active-high reset
//   req_{a,b}_valid/addr/data, req_*_ready : write request handshakes
//   clear_start                           : pulse requesting a full-buffer fill
//   clear_busy                            : fill in progress
//   oob_drop                              : accepted request discarded (addr out of range)
//   mem_px_addr, mem_px_data, px_wr       : registered frame-buffer write port
module fb_write_arbiter
  import fb_pkg::state_t, fb_pkg::ST_ARB, fb_pkg::ST_CLEAR, fb_pkg::RGB_BLACK;
#(
  parameter int            AW          = fb_pkg::AW,
  parameter int            DW          = fb_pkg::DW,
  parameter int            FB_WORDS    = fb_pkg::FB_WORDS,
  parameter logic [DW-1:0] CLEAR_COLOR = RGB_BLACK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a_valid,
  input  logic [AW-1:0] req_a_addr,
  input  logic [DW-1:0] req_a_data,
  output logic          req_a_ready,
  input  logic          req_b_valid,
  input  logic [AW-1:0] req_b_addr,
  input  logic [DW-1:0] req_b_data,
  output logic          req_b_ready,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic          oob_drop,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr
);

  // One extra bit so the limit itself is representable for the range compare
  localparam logic [AW:0]   LIMIT = (AW+1)'(FB_WORDS);
  localparam logic [AW-1:0] LAST  = AW'(FB_WORDS - 1);

  state_t        state;
  logic [AW-1:0] cnt;
  logic          arb_en;
  logic          gnt_a, gnt_b;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          sel_oob;

`ifdef FB_WRITE_ARB_CLEAR_EN
  state_t state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ARB;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  // clear_start pre-empts arbitration in the cycle it arrives
  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    case (state)
      ST_ARB: begin
        if (clear_start) state_nxt = ST_CLEAR;
        else             arb_en    = 1'b1;
      end
      ST_CLEAR: begin
        if (cnt == LAST) state_nxt = ST_ARB;
      end
    endcase
  end

  assign clear_busy = (state == ST_CLEAR);
`else
  logic unused_clear_start;

  assign state              = ST_ARB;
  assign cnt                = '0;
  assign arb_en             = 1'b1;
  assign clear_busy         = 1'b0;
  assign unused_clear_start = clear_start;
`endif

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en && !rst),
    .req_a (req_a_valid),
    .req_b (req_b_valid),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign req_a_ready = gnt_a;
  assign req_b_ready = gnt_b;

  assign sel_addr = gnt_b ? req_b_addr : req_a_addr;
  assign sel_data = gnt_b ? req_b_data : req_a_data;
  assign sel_oob  = ({1'b0, sel_addr} >= LIMIT);

  // Address/data only move on a real write, so they hold across idle and dropped cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      px_wr       <= 1'b0;
      oob_drop    <= 1'b0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
    end else begin
      px_wr    <= 1'b0;
      oob_drop <= 1'b0;
      if (state == ST_CLEAR) begin
        px_wr       <= 1'b1;
        mem_px_addr <= cnt;
        mem_px_data <= CLEAR_COLOR;
      end else if (gnt_a || gnt_b) begin
        if (sel_oob) begin
          oob_drop <= 1'b1;
        end else begin
          px_wr       <= 1'b1;
          mem_px_addr <= sel_addr;
          mem_px_data <= sel_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - scoreboard bench for fb_write_arbiter
module tb_fb_write_arbiter;

  localparam int AW = 19;
  localparam int DW = 12;
`ifdef FB_WRITE_ARB_CLEAR_EN
  localparam int TB_WORDS = 2048;
`else
  localparam int TB_WORDS = 307200;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a_valid, req_b_valid;
  logic [AW-1:0] req_a_addr, req_b_addr;
  logic [DW-1:0] req_a_data, req_b_data;
  logic          req_a_ready, req_b_ready;
  logic          clear_start, clear_busy, oob_drop, px_wr;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .AW          (AW),
    .DW          (DW),
    .FB_WORDS    (TB_WORDS),
    .CLEAR_COLOR (12'h000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_a_valid (req_a_valid),
    .req_a_addr  (req_a_addr),
    .req_a_data  (req_a_data),
    .req_a_ready (req_a_ready),
    .req_b_valid (req_b_valid),
    .req_b_addr  (req_b_addr),
    .req_b_data  (req_b_data),
    .req_b_ready (req_b_ready),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .oob_drop    (oob_drop),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          oob;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.oob  = (int'(a) >= TB_WORDS);
    exp_q.push_back(e);
  endtask

  // One clock: check readies/busy mid-cycle, queue the write the bench expects
  task automatic cycle(input string name, input logic ea, input logic eb, input logic ebusy);
    @(negedge clk);
    check({name, "_ready_a"}, 32'(req_a_ready), 32'(ea));
    check({name, "_ready_b"}, 32'(req_b_ready), 32'(eb));
    check({name, "_busy"}, 32'(clear_busy), 32'(ebusy));
    if (ea) push_exp(req_a_addr, req_a_data);
    if (eb) push_exp(req_b_addr, req_b_data);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write or drop pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (px_wr === 1'b1 || oob_drop === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_output: px_wr %b oob_drop %b addr %0d data %0h, nothing expected",
                 px_wr, oob_drop, mem_px_addr, mem_px_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_px_wr", 32'(px_wr), 32'(!mon_e.oob));
        check("mon_oob_drop", 32'(oob_drop), 32'(mon_e.oob));
        if (!mon_e.oob) begin
          check("mon_addr", 32'(mem_px_addr), 32'(mon_e.addr));
          check("mon_data", 32'(mem_px_data), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    clear_start = 1'b0;
    req_a_valid = 1'b0;
    req_b_valid = 1'b0;
    req_a_addr  = '0;
    req_b_addr  = '0;
    req_a_data  = '0;
    req_b_data  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state; valids high but readies must stay low under reset
    req_a_valid = 1'b1;
    req_b_valid = 1'b1;
    req_a_addr  = 19'd10;
    req_a_data  = 12'h111;
    req_b_addr  = 19'd20;
    req_b_data  = 12'h222;
    @(negedge clk);
    check("rst_px_wr", 32'(px_wr), 32'd0);
    check("rst_addr", 32'(mem_px_addr), 32'd0);
    check("rst_data", 32'(mem_px_data), 32'd0);
    check("rst_oob", 32'(oob_drop), 32'd0);
    check("rst_busy", 32'(clear_busy), 32'd0);
    check("rst_ready_a", 32'(req_a_ready), 32'd0);
    check("rst_ready_b", 32'(req_b_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Continuous contention: A, B, A, B
    cycle("rr1", 1'b1, 1'b0, 1'b0);
    req_a_addr = 19'd11; req_a_data = 12'h333;
    cycle("rr2", 1'b0, 1'b1, 1'b0);
    req_b_addr = 19'd21; req_b_data = 12'h444;
    cycle("rr3", 1'b1, 1'b0, 1'b0);
    cycle("rr4", 1'b0, 1'b1, 1'b0);
    req_a_valid = 1'b0;
    req_b_valid = 1'b0;
    cycle("idle1", 1'b0, 1'b0, 1'b0);

    // A alone, granted the same cycle
    req_a_valid = 1'b1; req_a_addr = 19'd100; req_a_data = 12'hF00;
    cycle("a_alone", 1'b1, 1'b0, 1'b0);
    req_a_valid = 1'b0;

    // B at the last legal word, then one past the end (dropped)
    req_b_valid = 1'b1; req_b_addr = 19'(TB_WORDS - 1); req_b_data = 12'h0F0;
    cycle("b_last_word", 1'b0, 1'b1, 1'b0);
    req_b_addr = 19'(TB_WORDS); req_b_data = 12'h00F;
    cycle("b_oob", 1'b0, 1'b1, 1'b0);
    req_b_valid = 1'b0;
    cycle("idle2", 1'b0, 1'b0, 1'b0);

    // Last grant was B (the dropped one) -> A wins contention
    req_a_valid = 1'b1; req_a_addr = 19'd200; req_a_data = 12'hABC;
    req_b_valid = 1'b1; req_b_addr = 19'd300; req_b_data = 12'hDEF;
    cycle("cont_after_b", 1'b1, 1'b0, 1'b0);
    req_a_valid = 1'b0;
    cycle("b_pending", 1'b0, 1'b1, 1'b0);
    req_b_valid = 1'b0;

    // A twice alone, then contention -> B wins, then A
    req_a_valid = 1'b1; req_a_addr = 19'd1; req_a_data = 12'h00A;
    cycle("a_solo1", 1'b1, 1'b0, 1'b0);
    req_a_addr = 19'd2; req_a_data = 12'h00B;
    cycle("a_solo2", 1'b1, 1'b0, 1'b0);
    req_a_addr = 19'd3; req_a_data = 12'h00C;
    req_b_valid = 1'b1; req_b_addr = 19'd4; req_b_data = 12'h00D;
    cycle("cont_after_a", 1'b0, 1'b1, 1'b0);
    req_b_valid = 1'b0;
    cycle("a_after_b", 1'b1, 1'b0, 1'b0);

    // A at the top of the address space is dropped
    req_a_addr = 19'h7FFFF; req_a_data = 12'h777;
    cycle("a_oob_max", 1'b1, 1'b0, 1'b0);
    req_a_valid = 1'b0;
    cycle("idle3", 1'b0, 1'b0, 1'b0);

`ifndef FB_WRITE_ARB_CLEAR_EN
    // Without the clear engine the pulse changes nothing
    clear_start = 1'b1;
    req_a_valid = 1'b1; req_a_addr = 19'd400; req_a_data = 12'h555;
    cycle("clr_ignored", 1'b1, 1'b0, 1'b0);
    clear_start = 1'b0;
    req_a_valid = 1'b0;
    cycle("clr_ignored_idle", 1'b0, 1'b0, 1'b0);
`else
    // Full clear with A waiting
    clear_start = 1'b1;
    req_a_valid = 1'b1; req_a_addr = 19'd400; req_a_data = 12'h555;
    cycle("clr_start", 1'b0, 1'b0, 1'b0);
    clear_start = 1'b0;
    for (int i = 0; i < TB_WORDS; i++) begin
      push_exp(19'(i), 12'h000);
      cycle("clr_fill", 1'b0, 1'b0, 1'b1);
    end
    cycle("clr_done_a", 1'b1, 1'b0, 1'b0);
    req_a_valid = 1'b0;

    // Reset part-way through a second clear
    clear_start = 1'b1;
    cycle("clr2_start", 1'b0, 1'b0, 1'b0);
    clear_start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      push_exp(19'(i), 12'h000);
      cycle("clr2_fill", 1'b0, 1'b0, 1'b1);
    end
    rst = 1'b1;
    req_a_valid = 1'b1; req_a_addr = 19'd500; req_a_data = 12'h666;
    cycle("rst_abort", 1'b0, 1'b0, 1'b1);
    cycle("rst_hold", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cycle("post_rst_a", 1'b1, 1'b0, 1'b0);
    req_a_valid = 1'b0;
`endif

    repeat (3) cycle("drain", 1'b0, 1'b0, 1'b0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter AW, 19, frame-buffer address width.
REQ-002 Parameter DW, 12, pixel width (RGB444).
REQ-003 Parameter FB_WORDS, 307200, number of valid buffer words (640x480).
REQ-004 Parameter CLEAR_COLOR, 12'h000, fill value used by the clear engine.
REQ-005 Port clk, in, 1: single clock for all logic.
REQ-006 Port rst, in, 1: reset, synchronous, active-high.
REQ-007 Ports req_a_valid, in, 1; req_a_addr, in, AW; req_a_data, in, DW: requester A write request.
REQ-008 Port req_a_ready, out, 1: A's request is accepted this cycle.
REQ-009 Ports req_b_valid, req_b_addr, req_b_data, req_b_ready: same as REQ-007/008 for requester B.
REQ-010 Port clear_start, in, 1: single-cycle pulse requesting a full-buffer clear.
REQ-011 Port clear_busy, out, 1: clear engine active.
REQ-012 Port oob_drop, out, 1: one-cycle pulse; an accepted request was discarded as out of range.
REQ-013 Ports mem_px_addr, out, AW; mem_px_data, out, DW; px_wr, out, 1: frame-buffer write port.

Function
REQ-014 Transfer occurs when valid and ready are both high on a rising edge.
REQ-015 ready is combinational from valid, arbiter state and FSM state; at most one ready is high per cycle.
REQ-016 Requesters hold valid, addr and data stable until ready; dropping valid without ready is illegal.
REQ-017 When only one requester is valid in ARB, it is granted the same cycle.
REQ-018 When both are valid, grant goes to the requester not granted last; the last_grant register updates on every transfer.
REQ-019 Accepted write appears on mem_px_addr/mem_px_data with px_wr=1 exactly one cycle after transfer (registered outputs).
REQ-020 px_wr=0 in every cycle without a preceding transfer or clear write; addr/data hold their last values.
REQ-021 An accepted request with addr >= FB_WORDS yields px_wr=0 and oob_drop=1 in the output cycle.
REQ-022 FSM states: ARB (normal arbitration) and CLEAR (fill).
REQ-023 ARB -> CLEAR on clear_start; clear takes priority, so both readies are 0 in that cycle.
REQ-024 In CLEAR, counter runs 0..FB_WORDS-1, one write per cycle, with px_wr=1 and data=CLEAR_COLOR, registered like REQ-019.
REQ-025 In CLEAR, both readies are 0, clear_busy=1, and clear_start is ignored.
REQ-026 After the write at FB_WORDS-1, the FSM returns to ARB; clear_busy falls with the last write.
REQ-027 Counter arithmetic is AW bits wide; the terminal compare uses FB_WORDS-1 and never wraps.

Reset
REQ-028 On rst: state=ARB, counter=0, last_grant=B (A wins the first contention), px_wr=0, mem_px_addr=0, mem_px_data=0, oob_drop=0, clear_busy=0.
REQ-029 While rst=1, readies are 0.
REQ-030 rst during CLEAR aborts the fill; no further writes are issued.

Configuration
REQ-031 Macro FB_WRITE_ARB_CLEAR_EN defined: clear engine (CLEAR state, counter, REQ-023..027) is compiled in.
REQ-032 Macro undefined: FSM is permanently ARB, clear_start is ignored, clear_busy is tied 0, and ports are unchanged.

Structure
REQ-033 The shared package fb_pkg holds AW, DW, FB_WORDS, the RGB444 colour constants and the state enum.
REQ-034 One sub-module, rr_arb2 (two-way round-robin grant with last_grant register), is instantiated once.

Verification
REQ-035 A alone valid, addr=100, data=12'hF00 -> req_a_ready same cycle; next cycle px_wr=1, addr=100, data=F00.
REQ-036 A and B valid continuously after reset -> grants A,B,A,B; px_wr high every cycle.
REQ-037 B valid with addr=307200 -> B accepted, px_wr=0, oob_drop=1 one cycle later.
REQ-038 clear_start with A valid (macro defined) -> A stalled for 307200+1 cycles; addresses 0..307199 written with 000; A then granted.
REQ-039 rst asserted at clear counter 1000 -> px_wr=0 from the next cycle, clear_busy=0, A granted after rst falls.
REQ-040 Macro undefined, clear_start pulse -> no writes, clear_busy stays 0, arbitration unaffected.
